mem_port_arbiter: RTL

Shares the single 16-bit unified RAM port between instruction fetch (IF, read-only) and the data cache (DC, word read/write).
- Converts each 32-bit word access into two sequential 16-bit beats.
- Byte address A maps to low half at mem[A>>1] and high half at mem[(A>>1)+1].
- Sits between riscv_core and the ram instance inside riscv_top.

---
 rtl/mem_port_arbiter_pkg.sv | 8 +
 rtl/mem_arb_grant.sv | 28 ++
 rtl/mem_port_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared types for the unified RAM port arbiter.
// Contents: arb_state_t (sequencer states), grant_t (winning requester),
// HALF_BEATS (16-bit beats per 32-bit word).
package mem_port_arbiter_pkg;
  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, RD_CAP, WR_LO, WR_HI, ACK} arb_state_t;
  typedef enum logic {GNT_IF, GNT_DC} grant_t;
  localparam int HALF_BEATS = 2;
endpackage

// File: rtl/mem_arb_grant.sv
// mem_arb_grant: picks which requester owns the next RAM transaction.
// Ports: if_req/dc_req pending requests; gnt combinational winner.
// With MEM_ARB_RR_EN defined: clk, reset_n and grant_en are added and a
// last_grant register (reset GNT_IF) alternates the winner when both request.
// Without it: fixed DC priority, no state.
module mem_arb_grant
  import mem_port_arbiter_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic   clk,
  input  logic   reset_n,
  input  logic   grant_en,
`endif
  input  logic   if_req,
  input  logic   dc_req,
  output grant_t gnt
);
`ifdef MEM_ARB_RR_EN
  grant_t last_grant;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) last_grant <= GNT_IF;
    else if (grant_en) last_grant <= gnt;
  assign gnt = (if_req && dc_req) ? (last_grant == GNT_DC ? GNT_IF : GNT_DC)
                                  : (dc_req ? GNT_DC : GNT_IF);
`else
  assign gnt = dc_req ? GNT_DC : GNT_IF;
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 16-bit RAM port between IF (read) and DC (read/write),
// splitting each 32-bit word into two halfword beats (low half first).
// Ports: clk, reset_n (async active-low); if_req/if_addr -> if_rdata/if_ack;
// dc_req/dc_we/dc_addr/dc_wdata -> dc_rdata/dc_ack; ram_addr/ram_wdata/ram_we
// drive the RAM, ram_rdata returns data one cycle after ram_addr.
// Optional: MEM_ARB_RR_EN selects round-robin instead of fixed DC priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int RAM_AW = 13,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ack,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [31:0]       dc_wdata,
  output logic [31:0]       dc_rdata,
  output logic              dc_ack,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [15:0]       ram_wdata,
  output logic              ram_we,
  input  logic [15:0]       ram_rdata
);
  arb_state_t state, state_n;
  grant_t gnt, gnt_q;
  logic [RAM_AW-1:0] lo_q, lo_sel;
  logic [15:0] wdata_hi;
  logic start, unused_bits;

  assign start = (state == IDLE) && (if_req || dc_req);
  assign lo_sel = gnt == GNT_DC ? dc_addr[RAM_AW:1] : if_addr[RAM_AW:1];
  // Byte-lane bit and address bits above the RAM are deliberately dropped.
  assign unused_bits = ^{if_addr[ADDR_W-1:RAM_AW+1], if_addr[0], dc_addr[ADDR_W-1:RAM_AW+1], dc_addr[0]};

  mem_arb_grant u_grant (
`ifdef MEM_ARB_RR_EN
    .clk      (clk),
    .reset_n  (reset_n),
    .grant_en (start),
`endif
    .if_req   (if_req),
    .dc_req   (dc_req),
    .gnt      (gnt)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = (gnt == GNT_DC && dc_we) ? WR_LO : RD_LO;
      RD_LO:   state_n = RD_HI;
      RD_HI:   state_n = RD_CAP;
      RD_CAP:  state_n = ACK;
      WR_LO:   state_n = WR_HI;
      WR_HI:   state_n = ACK;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;

  // Outputs are registered from the next state so each beat's RAM controls
  // are valid for the whole cycle the sequencer spends in that beat.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      if_ack    <= 1'b0;
      dc_ack    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      if_rdata  <= '0;
      dc_rdata  <= '0;
      gnt_q     <= GNT_IF;
      lo_q      <= '0;
      wdata_hi  <= '0;
    end else begin
      if_ack <= state_n == ACK && gnt_q == GNT_IF;
      dc_ack <= state_n == ACK && gnt_q == GNT_DC;
      ram_we <= state_n == WR_LO || state_n == WR_HI;
      if (start) begin
        gnt_q     <= gnt;
        lo_q      <= lo_sel;
        wdata_hi  <= dc_wdata[31:16];
        ram_addr  <= lo_sel;
        ram_wdata <= dc_wdata[15:0];
      end
      if (state == RD_LO || state == WR_LO) begin
        ram_addr  <= lo_q + RAM_AW'(HALF_BEATS - 1);
        ram_wdata <= wdata_hi;
      end
      // RAM data lags the address by one cycle, so each half lands one state later.
      if (state == RD_HI) begin
        if (gnt_q == GNT_DC) dc_rdata[15:0] <= ram_rdata;
        else if_rdata[15:0] <= ram_rdata;
      end
      if (state == RD_CAP) begin
        if (gnt_q == GNT_DC) dc_rdata[31:16] <= ram_rdata;
        else if_rdata[31:16] <= ram_rdata;
      end
    end
endmodule
